// File: rtl/risc_fetch_queue_if.sv
// Handshake/bus bundle between the fetch queue, the instruction memory and decode.
// master: the fetch queue side. slave: the memory/decode environment side.
// Decode handshake: a word moves from queue to decode on every rising edge where
// inst_valid and inst_ready are both 1; inst/inst_pc hold steady while valid is
// up and ready is low.
interface risc_fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              im_cen;
    logic              im_oen;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_dataout;
    logic              halt;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_ready;
    logic [CNT_W-1:0]  q_count;

    modport master (
        output im_cen, im_oen, im_addr, inst_valid, inst, inst_pc, q_count,
        input  im_dataout, halt, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  im_cen, im_oen, im_addr, inst_valid, inst, inst_pc, q_count,
        output im_dataout, halt, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/risc_fetch_queue.sv
// Instruction-fetch front end: issues i-Mem reads, buffers returned words with
// their PC in a DEPTH-entry queue, and presents the head to decode.
// Optional feature macro: FETCH_STATS_EN adds saturating fetched/flushed counters.
// Issue is credit-based (occupancy + in-flight read < DEPTH) so a push never
// finds the queue full. A redirect empties the queue, drops the in-flight
// response and reloads the fetch PC; nothing is issued in the redirect cycle.
module risc_fetch_queue #(
    parameter int             DATA_W   = 32,
    parameter int             ADDR_W   = 11,
    parameter int             PC_W     = 32,
    parameter int             DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    risc_fetch_queue_if.master  bus,
    output logic [1:0]          dbg_state_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]         stat_fetched,
    output logic [31:0]         stat_flushed
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic              pending_q, pending_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic credit_ok;
    logic issue_ok;
    logic issue;
    logic push;
    logic pop;
    logic head_valid;

    // Credit and handshake qualifiers; redirect overrides push, pop and issue.
    always_comb begin
        credit_ok  = ((CNT_W+1)'(count_q) + (CNT_W+1)'(pending_q)) < (CNT_W+1)'(DEPTH);
        issue_ok   = !bus.halt && !bus.redirect && credit_ok;
        issue      = (state_q == S_FETCH) && issue_ok;
        head_valid = (count_q != '0);
        push       = pending_q && !bus.redirect;
        pop        = head_valid && bus.inst_ready && !bus.redirect;
    end

    // Next-state logic of the fetch FSM; redirect always lands in FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (!issue_ok) state_d = S_HOLD;
            S_HOLD:  if (issue_ok)  state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
        if (bus.redirect) state_d = S_FETCH;
    end

    // Next-state logic for fetch PC, in-flight tracking and queue pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pending_d  = issue;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + PC_W'(1);
                pend_pc_d  = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            pending_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are only observed through valid entries, so no reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_mem[wr_ptr_q] <= bus.im_dataout;
            pc_mem[wr_ptr_q]   <= pend_pc_q;
        end
    end

    // Outputs: head is forced to zero when empty so reset values are clean.
    always_comb begin
        bus.im_cen     = !issue;
        bus.im_oen     = 1'b0;
        bus.im_addr    = fetch_pc_q[ADDR_W-1:0];
        bus.inst_valid = head_valid;
        bus.inst       = head_valid ? data_mem[rd_ptr_q] : '0;
        bus.inst_pc    = head_valid ? pc_mem[rd_ptr_q]   : '0;
        bus.q_count    = count_q;
        dbg_state_o    = state_q;
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_flushed_q, stat_flushed_d;
    logic [32:0] fetched_sum;
    logic [32:0] flushed_sum;

    // Saturating counters: words pushed, and words thrown away by redirects.
    always_comb begin
        fetched_sum    = {1'b0, stat_fetched_q} + 33'(push);
        flushed_sum    = {1'b0, stat_flushed_q} + 33'(count_q) + 33'(pending_q);
        stat_fetched_d = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
        stat_flushed_d = stat_flushed_q;
        if (bus.redirect)
            stat_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched_q <= '0;
            stat_flushed_q <= '0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_flushed_q <= stat_flushed_d;
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_flushed = stat_flushed_q;
`endif
endmodule
